ps2_init_sequencer: RTL and testbench
=====================================

// Module: ps2_init_sequencer
// PURPOSE
//  Controller that sequences the PS/2 host-to-device command transmitter and the receive path.
//  After start, it runs a fixed mouse init script: FF reset, wait BAT AA, drain ID, F3 + rate, F4 enable.
//  Each step checks the device ACK and retries on failure; afterwards it arbitrates a software command port.
//  Sits between the PS/2 command-out/data-in blocks and the bus register interface.
// PARAMETERS
//  ACK_TIMEOUT_CYCLES  2000000    max cycles from command_was_sent to ACK byte (20 ms @100 MHz)
//  BAT_TIMEOUT_CYCLES  100000000  max cycles from reset ACK to AA (1 s @100 MHz)
//  DRAIN_CYCLES        1000000    window after AA in which extra bytes (mouse ID 00) are discarded
//  MAX_RETRIES         3          retries per step before init_error (attempts = MAX_RETRIES+1)
//  SAMPLE_RATE         8'd100     argument sent after F3
// PORTS
//  clk             in   1  system clock
//  reset           in   1  synchronous, active-high
//  start           in   1  pulse: (re)start init script; ignored unless in IDLE, DONE or FAIL
//  the_command     out  8  byte to transmitter; stable while send_command=1
//  send_command    out  1  transmit request, level held until completion flag seen
//  command_was_sent in  1  transmitter success flag (clears after send_command drops)
//  error_communication_timed_out in 1  transmitter timeout flag
//  rx_data         in   8  received byte
//  rx_valid        in   1  one-cycle strobe, rx_data valid
//  sw_cmd          in   8  software command byte
//  sw_cmd_valid    in   1  software request; accepted when sw_cmd_ready=1
//  sw_cmd_ready    out  1  high only in DONE
//  sw_done         out  1  one-cycle pulse: software command finished
//  sw_ack_ok       out  1  valid with sw_done: 1 = FA received, 0 = FE/FC/other/timeout
//  rx_out_data     out  8  pass-through stream byte
//  rx_out_valid    out  1  one-cycle pulse: rx byte not consumed by sequencer (DONE, no ACK pending)
//  init_done       out  1  level: script completed
//  init_error      out  1  level: retries exhausted
//  busy            out  1  state not IDLE/DONE/FAIL
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, retry counter 0, step 0, timers 0. Reset mid-transfer drops send_command same cycle.
//  Script ROM (step:byte:expect): 0:FF:FA then AA | 1:F3:FA | 2:SAMPLE_RATE:FA | 3:F4:FA.
//  States: IDLE, LOAD, SEND, RELEASE, WAIT_ACK, WAIT_BAT, DRAIN, DONE, FAIL, SW_SEND, SW_RELEASE, SW_WAIT_ACK.
//  IDLE/DONE/FAIL --start--> LOAD (step=0, retries=0, init_done/init_error cleared).
//  LOAD: the_command<=ROM[step]; next SEND.
//  SEND: send_command=1 until command_was_sent or error_communication_timed_out sampled high; then RELEASE.
//  RELEASE: send_command=0; wait until both flags low (min 1 cycle); then WAIT_ACK on success flag, retry on timeout flag.
//  WAIT_ACK: timer counts from 0; rx FA -> step 0: WAIT_BAT, else step+1 (after step 3: DONE, init_done=1).
//    rx FE, FC, any other byte, or timer==ACK_TIMEOUT_CYCLES -> retry.
//  WAIT_BAT: rx AA -> DRAIN; rx FC or timer==BAT_TIMEOUT_CYCLES -> retry (resend FF); other bytes ignored.
//  DRAIN: discard all rx for DRAIN_CYCLES, then step=1, LOAD.
//  Retry: if retries==MAX_RETRIES -> FAIL (init_error=1, busy=0); else retries+1 and LOAD same step. retries resets to 0 on each step advance.
//  Bytes arriving in SEND/RELEASE are discarded (device ACK cannot precede send completion).
//  rx_valid coincident with timer expiry: byte wins (evaluated first).
//  DONE: rx not consumed -> rx_out_valid pulse next cycle with rx_out_data. start and sw_cmd_valid in same cycle: start wins.
//  Timers saturate at their limit; cleared on every state entry. Widths from $clog2(limit+1).
// CONFIGURATION
//  PS2_SW_CMD_PORT_EN defined: DONE + sw_cmd_valid -> the_command<=sw_cmd, SW_SEND/SW_RELEASE as SEND/RELEASE;
//    SW_WAIT_ACK: FA -> sw_done=1,sw_ack_ok=1; other byte, transmitter timeout or ACK timeout -> sw_done=1,sw_ack_ok=0; no retry; return DONE.
//  Not defined: sw_* inputs ignored, sw_cmd_ready/sw_done/sw_ack_ok tied 0; SW_* states absent.
// TESTING
//  start; device model: sent flag, FA, AA, 00 -> bytes FF,F3,64,F4 each with FA; init_done=1, no rx_out_valid for 00.
//  Step 1 replies FE twice then FA -> F3 sent 3 times; init_done=1, init_error=0.
//  Device never ACKs (MAX_RETRIES=3) -> FF sent 4 times, init_error=1, busy=0, send_command=0.
//  error_communication_timed_out on first FF -> FF resent after flags drop; send_command low >=1 cycle between.
//  DONE, rx 08 -> rx_out_valid pulse, rx_out_data=08; reset asserted during SEND -> send_command=0 next cycle, IDLE.
//  PS2_SW_CMD_PORT_EN, sw_cmd=F5, reply FA -> sw_done=1,sw_ack_ok=1; reply FC -> sw_ack_ok=0.

Source files
------------

// File: rtl/ps2_init_sequencer_if.sv
`default_nettype none
//==============================================================================
// Module      : ps2_init_sequencer_if
// Description : Bundles the transmitter, receive stream, software command port
//               and status signals of the PS/2 init sequencer. The sequencer
//               uses the master view; the surrounding fabric uses the slave view.
// Revision    : 1.0 - initial release
//==============================================================================
interface ps2_init_sequencer_if;
    logic       start;
    logic [7:0] the_command;
    logic       send_command;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] sw_cmd;
    logic       sw_cmd_valid;
    logic       sw_cmd_ready;
    logic       sw_done;
    logic       sw_ack_ok;
    logic [7:0] rx_out_data;
    logic       rx_out_valid;
    logic       init_done;
    logic       init_error;
    logic       busy;

    modport master (
        input  start, command_was_sent, error_communication_timed_out,
               rx_data, rx_valid, sw_cmd, sw_cmd_valid,
        output the_command, send_command, sw_cmd_ready, sw_done, sw_ack_ok,
               rx_out_data, rx_out_valid, init_done, init_error, busy
    );

    modport slave (
        output start, command_was_sent, error_communication_timed_out,
               rx_data, rx_valid, sw_cmd, sw_cmd_valid,
        input  the_command, send_command, sw_cmd_ready, sw_done, sw_ack_ok,
               rx_out_data, rx_out_valid, init_done, init_error, busy
    );
endinterface
`default_nettype wire

// File: rtl/ps2_init_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : ps2_init_sequencer
// Description : Runs the PS/2 mouse init script (FF reset + BAT, F3 + rate,
//               F4 enable) with per-step ACK checking and bounded retries, then
//               passes unconsumed receive bytes downstream.
// Config      : define PS2_SW_CMD_PORT_EN to enable the software command port
//               (SW_SEND / SW_RELEASE / SW_WAIT_ACK); otherwise sw_* is inert.
// Revision    : 1.0 - initial release
//==============================================================================
module ps2_init_sequencer #(
    parameter int unsigned ACK_TIMEOUT_CYCLES = 2000000,
    parameter int unsigned BAT_TIMEOUT_CYCLES = 100000000,
    parameter int unsigned DRAIN_CYCLES       = 1000000,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter logic [7:0]  SAMPLE_RATE        = 8'd100
) (
    input  logic                clk,
    input  logic                reset,
    ps2_init_sequencer_if.master bus
);

    // One shared timer serves every waiting state, so it is sized for the largest limit.
    localparam int unsigned C_MAX_A   = (ACK_TIMEOUT_CYCLES > BAT_TIMEOUT_CYCLES) ? ACK_TIMEOUT_CYCLES : BAT_TIMEOUT_CYCLES;
    localparam int unsigned C_MAX_LIM = (C_MAX_A > DRAIN_CYCLES) ? C_MAX_A : DRAIN_CYCLES;
    localparam int          TW        = $clog2(C_MAX_LIM + 1);
    localparam int          RW        = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [TW-1:0] C_ACK_LIM   = TW'(ACK_TIMEOUT_CYCLES);
    localparam logic [TW-1:0] C_BAT_LIM   = TW'(BAT_TIMEOUT_CYCLES);
    localparam logic [TW-1:0] C_DRAIN_LIM = TW'(DRAIN_CYCLES);
    localparam logic [RW-1:0] C_MAX_RETRY = RW'(MAX_RETRIES);

    localparam logic [7:0] C_BYTE_ACK    = 8'hFA;
    localparam logic [7:0] C_BYTE_DEVERR = 8'hFC;
    localparam logic [7:0] C_BYTE_BAT_OK = 8'hAA;

    localparam logic [3:0] C_ST_IDLE        = 4'd0;
    localparam logic [3:0] C_ST_LOAD        = 4'd1;
    localparam logic [3:0] C_ST_SEND        = 4'd2;
    localparam logic [3:0] C_ST_RELEASE     = 4'd3;
    localparam logic [3:0] C_ST_WAIT_ACK    = 4'd4;
    localparam logic [3:0] C_ST_WAIT_BAT    = 4'd5;
    localparam logic [3:0] C_ST_DRAIN       = 4'd6;
    localparam logic [3:0] C_ST_DONE        = 4'd7;
    localparam logic [3:0] C_ST_FAIL        = 4'd8;
`ifdef PS2_SW_CMD_PORT_EN
    localparam logic [3:0] C_ST_SW_SEND     = 4'd9;
    localparam logic [3:0] C_ST_SW_RELEASE  = 4'd10;
    localparam logic [3:0] C_ST_SW_WAIT_ACK = 4'd11;
`endif

    // Script ROM: reset, set-sample-rate, rate argument, enable reporting.
    function automatic logic [7:0] rom_byte(input logic [1:0] s);
        case (s)
            2'd0:    rom_byte = 8'hFF;
            2'd1:    rom_byte = 8'hF3;
            2'd2:    rom_byte = SAMPLE_RATE;
            default: rom_byte = 8'hF4;
        endcase
    endfunction

    logic [3:0]    state_q, state_d;
    logic [1:0]    step_q, step_d;
    logic [RW-1:0] retries_q, retries_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    cmd_q, cmd_d;
    logic          tx_ok_q, tx_ok_d;
    logic          init_done_q, init_done_d;
    logic          init_error_q, init_error_d;
    logic [7:0]    rx_out_data_q, rx_out_data_d;
    logic          rx_out_valid_q, rx_out_valid_d;
    logic          w_retry;
    logic          w_flags_low;
    logic          w_send;
    logic [TW-1:0] w_limit;
`ifdef PS2_SW_CMD_PORT_EN
    logic          sw_done_q, sw_done_d;
    logic          sw_ack_ok_q, sw_ack_ok_d;
`endif

    assign w_flags_low = !bus.command_was_sent && !bus.error_communication_timed_out;

    // Next-state, script sequencing, retry accounting and stream pass-through.
    always_comb begin
        state_d        = state_q;
        step_d         = step_q;
        retries_d      = retries_q;
        cmd_d          = cmd_q;
        tx_ok_d        = tx_ok_q;
        init_done_d    = init_done_q;
        init_error_d   = init_error_q;
        rx_out_data_d  = rx_out_data_q;
        rx_out_valid_d = 1'b0;
        w_retry        = 1'b0;
`ifdef PS2_SW_CMD_PORT_EN
        sw_done_d      = 1'b0;
        sw_ack_ok_d    = 1'b0;
`endif
        case (state_q)
            C_ST_IDLE, C_ST_DONE, C_ST_FAIL: begin
                // In DONE nothing is waiting for an ACK, so every byte goes downstream.
                if (state_q == C_ST_DONE && bus.rx_valid) begin
                    rx_out_valid_d = 1'b1;
                    rx_out_data_d  = bus.rx_data;
                end
                if (bus.start) begin
                    state_d      = C_ST_LOAD;
                    step_d       = 2'd0;
                    retries_d    = '0;
                    init_done_d  = 1'b0;
                    init_error_d = 1'b0;
                end
`ifdef PS2_SW_CMD_PORT_EN
                else if (state_q == C_ST_DONE && bus.sw_cmd_valid) begin
                    cmd_d   = bus.sw_cmd;
                    state_d = C_ST_SW_SEND;
                end
`endif
            end
            C_ST_LOAD: begin
                cmd_d   = rom_byte(step_q);
                state_d = C_ST_SEND;
            end
            C_ST_SEND: begin
                if (bus.command_was_sent) begin
                    tx_ok_d = 1'b1;
                    state_d = C_ST_RELEASE;
                end else if (bus.error_communication_timed_out) begin
                    tx_ok_d = 1'b0;
                    state_d = C_ST_RELEASE;
                end
            end
            C_ST_RELEASE: begin
                if (w_flags_low) begin
                    if (tx_ok_q) state_d = C_ST_WAIT_ACK;
                    else         w_retry = 1'b1;
                end
            end
            C_ST_WAIT_ACK: begin
                // A byte arriving on the expiry cycle is judged before the timeout.
                if (bus.rx_valid) begin
                    if (bus.rx_data == C_BYTE_ACK) begin
                        if (step_q == 2'd0) begin
                            state_d = C_ST_WAIT_BAT;
                        end else if (step_q == 2'd3) begin
                            state_d     = C_ST_DONE;
                            init_done_d = 1'b1;
                        end else begin
                            step_d    = step_q + 2'd1;
                            retries_d = '0;
                            state_d   = C_ST_LOAD;
                        end
                    end else begin
                        w_retry = 1'b1;
                    end
                end else if (timer_q == C_ACK_LIM) begin
                    w_retry = 1'b1;
                end
            end
            C_ST_WAIT_BAT: begin
                if (bus.rx_valid && bus.rx_data == C_BYTE_BAT_OK) begin
                    state_d = C_ST_DRAIN;
                end else if (bus.rx_valid && bus.rx_data == C_BYTE_DEVERR) begin
                    w_retry = 1'b1;
                end else if (timer_q == C_BAT_LIM) begin
                    w_retry = 1'b1;
                end
            end
            C_ST_DRAIN: begin
                // Device ID byte(s) after BAT are swallowed here.
                if (timer_q == C_DRAIN_LIM) begin
                    step_d    = 2'd1;
                    retries_d = '0;
                    state_d   = C_ST_LOAD;
                end
            end
`ifdef PS2_SW_CMD_PORT_EN
            C_ST_SW_SEND: begin
                if (bus.command_was_sent) begin
                    tx_ok_d = 1'b1;
                    state_d = C_ST_SW_RELEASE;
                end else if (bus.error_communication_timed_out) begin
                    tx_ok_d = 1'b0;
                    state_d = C_ST_SW_RELEASE;
                end
            end
            C_ST_SW_RELEASE: begin
                if (w_flags_low) begin
                    if (tx_ok_q) begin
                        state_d = C_ST_SW_WAIT_ACK;
                    end else begin
                        sw_done_d = 1'b1;
                        state_d   = C_ST_DONE;
                    end
                end
            end
            C_ST_SW_WAIT_ACK: begin
                if (bus.rx_valid) begin
                    sw_done_d   = 1'b1;
                    sw_ack_ok_d = (bus.rx_data == C_BYTE_ACK);
                    state_d     = C_ST_DONE;
                end else if (timer_q == C_ACK_LIM) begin
                    sw_done_d = 1'b1;
                    state_d   = C_ST_DONE;
                end
            end
`endif
            default: state_d = C_ST_IDLE;
        endcase

        // Failed attempt: repeat the same step until the budget is spent.
        if (w_retry) begin
            if (retries_q == C_MAX_RETRY) begin
                state_d      = C_ST_FAIL;
                init_error_d = 1'b1;
            end else begin
                retries_d = retries_q + 1'b1;
                state_d   = C_ST_LOAD;
            end
        end
    end

    // Per-state timer limit; states without a timeout keep the timer at zero.
    always_comb begin
        w_limit = '0;
        case (state_q)
            C_ST_WAIT_ACK: w_limit = C_ACK_LIM;
            C_ST_WAIT_BAT: w_limit = C_BAT_LIM;
            C_ST_DRAIN:    w_limit = C_DRAIN_LIM;
`ifdef PS2_SW_CMD_PORT_EN
            C_ST_SW_WAIT_ACK: w_limit = C_ACK_LIM;
`endif
            default:       w_limit = '0;
        endcase
    end

    // Timer restarts on every state change and saturates at its limit.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q)    timer_d = '0;
        else if (timer_q != w_limit) timer_d = timer_q + 1'b1;
    end

    // Transmit request is a pure state decode, gated so reset drops it immediately.
    always_comb begin
        w_send = (state_q == C_ST_SEND);
`ifdef PS2_SW_CMD_PORT_EN
        if (state_q == C_ST_SW_SEND) w_send = 1'b1;
`endif
        w_send = w_send && !reset;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= C_ST_IDLE;
            step_q         <= 2'd0;
            retries_q      <= '0;
            timer_q        <= '0;
            cmd_q          <= 8'h00;
            tx_ok_q        <= 1'b0;
            init_done_q    <= 1'b0;
            init_error_q   <= 1'b0;
            rx_out_data_q  <= 8'h00;
            rx_out_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            retries_q      <= retries_d;
            timer_q        <= timer_d;
            cmd_q          <= cmd_d;
            tx_ok_q        <= tx_ok_d;
            init_done_q    <= init_done_d;
            init_error_q   <= init_error_d;
            rx_out_data_q  <= rx_out_data_d;
            rx_out_valid_q <= rx_out_valid_d;
        end
    end

    assign bus.the_command  = cmd_q;
    assign bus.send_command = w_send;
    assign bus.rx_out_data  = rx_out_data_q;
    assign bus.rx_out_valid = rx_out_valid_q;
    assign bus.init_done    = init_done_q;
    assign bus.init_error   = init_error_q;
    assign bus.busy         = (state_q != C_ST_IDLE) && (state_q != C_ST_DONE) && (state_q != C_ST_FAIL);

`ifdef PS2_SW_CMD_PORT_EN
    // Software command completion pulse and its verdict.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_done_q   <= 1'b0;
            sw_ack_ok_q <= 1'b0;
        end else begin
            sw_done_q   <= sw_done_d;
            sw_ack_ok_q <= sw_ack_ok_d;
        end
    end

    assign bus.sw_cmd_ready = (state_q == C_ST_DONE);
    assign bus.sw_done      = sw_done_q;
    assign bus.sw_ack_ok    = sw_ack_ok_q;
`else
    logic w_unused_sw;
    assign w_unused_sw      = ^{bus.sw_cmd, bus.sw_cmd_valid};
    assign bus.sw_cmd_ready = 1'b0;
    assign bus.sw_done      = 1'b0;
    assign bus.sw_ack_ok    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_init_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : tb_ps2_init_sequencer
// Description : Bench for ps2_init_sequencer: a reactive PS/2 device model
//               follows a per-attempt response plan; a script-level reference
//               derives the expected command stream and final status.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_ps2_init_sequencer;

    localparam int unsigned ACK_TO = 40;
    localparam int unsigned BAT_TO = 60;
    localparam int unsigned DRAIN  = 30;
    localparam int unsigned MAXR   = 3;

    // Reply kinds: 0 FA, 1 FE, 2 FC, 3 other byte, 4 silence
    // BAT kinds:   0 AA, 1 FC, 2 silence
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ps2_init_sequencer_if bus();

    ps2_init_sequencer #(
        .ACK_TIMEOUT_CYCLES (ACK_TO),
        .BAT_TIMEOUT_CYCLES (BAT_TO),
        .DRAIN_CYCLES       (DRAIN),
        .MAX_RETRIES        (MAXR),
        .SAMPLE_RATE        (8'd100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_out    = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] script[4] = '{8'hFF, 8'hF3, 8'h64, 8'hF4};
    bit         plan_txto[32];
    int         plan_reply[32];
    int         plan_bat[32];
    bit         plan_junk[32];
    bit         exp_done;
    bit         exp_err;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.rx_out_valid) n_out++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    // Device side of one command: flag completion, then answer per plan.
    task automatic dev_txn(input bit txto, input int rk, input int bk, input bit junk);
        logic [7:0] cmd;
        logic [7:0] other;
        cmd = bus.the_command;
        got_q.push_back(cmd);
        repeat ($urandom_range(1, 4)) tick();
        if (txto) bus.error_communication_timed_out = 1'b1;
        else      bus.command_was_sent = 1'b1;
        for (int i = 0; i < 50 && bus.send_command; i++) tick();
        tick();
        bus.command_was_sent              = 1'b0;
        bus.error_communication_timed_out = 1'b0;
        if (txto || rk == 4) return;
        repeat ($urandom_range(1, 8)) tick();
        other = 8'($urandom_range(0, 255));
        if (other == 8'hFA) other = 8'h55;
        case (rk)
            0:       send_byte(8'hFA);
            1:       send_byte(8'hFE);
            2:       send_byte(8'hFC);
            default: send_byte(other);
        endcase
        if (rk != 0 || cmd != 8'hFF) return;
        if (junk) begin
            repeat ($urandom_range(1, 4)) tick();
            send_byte(8'h00);
        end
        if (bk == 2) return;
        repeat ($urandom_range(1, 8)) tick();
        send_byte(bk == 0 ? 8'hAA : 8'hFC);
        if (bk == 0) begin
            repeat ($urandom_range(1, 5)) tick();
            send_byte(8'h00);
        end
    endtask

    // Script-level reference: walk the steps, spending attempts from the plan.
    function automatic void ref_model();
        int step    = 0;
        int retries = 0;
        bit ok;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        for (int k = 0; k < 32; k++) begin
            exp_q.push_back(script[step]);
            ok = !plan_txto[k] && plan_reply[k] == 0 && (step != 0 || plan_bat[k] == 0);
            if (ok) begin
                if (step == 3) begin
                    exp_done = 1'b1;
                    break;
                end
                step++;
                retries = 0;
            end else if (retries == int'(MAXR)) begin
                exp_err = 1'b1;
                break;
            end else begin
                retries++;
            end
        end
    endfunction

    task automatic plan_clear();
        for (int k = 0; k < 32; k++) begin
            plan_txto[k] = 1'b0; plan_reply[k] = 0; plan_bat[k] = 0; plan_junk[k] = 1'b0;
        end
    endtask

    task automatic plan_random();
        int p;
        p = int'($urandom_range(55, 95));
        for (int k = 0; k < 32; k++) begin
            plan_txto[k]  = ($urandom_range(0, 99) < 5);
            plan_reply[k] = (int'($urandom_range(0, 99)) < p) ? 0 : int'($urandom_range(1, 4));
            plan_bat[k]   = (int'($urandom_range(0, 99)) < p) ? 0 : int'($urandom_range(1, 2));
            plan_junk[k]  = ($urandom_range(0, 99) < 30);
        end
    endtask

    task automatic run_scenario(input string name);
        int k;
        bit to;
        logic [31:0] g;
        logic [7:0]  b;
        ref_model();
        got_q.delete();
        n_out = 0;
        k  = 0;
        to = 1'b1;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (!bus.busy) begin
                to = 1'b0;
                break;
            end
            if (bus.send_command) begin
                dev_txn(plan_txto[k], plan_reply[k], plan_bat[k], plan_junk[k]);
                if (k < 31) k++;
            end else begin
                tick();
            end
        end
        check_val({name, " timeout"}, 32'(to), 32'd0);
        check_val({name, " ncmds"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD;
            check_val($sformatf("%s cmd%0d", name, i), g, 32'(exp_q[i]));
        end
        check_val({name, " init_done"}, 32'(bus.init_done), 32'(exp_done));
        check_val({name, " init_error"}, 32'(bus.init_error), 32'(exp_err));
        check_val({name, " busy"}, 32'(bus.busy), 32'd0);
        check_val({name, " send_command"}, 32'(bus.send_command), 32'd0);
        check_val({name, " rx_out during init"}, 32'(n_out), 32'd0);
        if (exp_done) begin
            for (int j = 0; j < 2; j++) begin
                b = 8'($urandom_range(0, 255));
                bus.rx_data  = b;
                bus.rx_valid = 1'b1;
                tick();
                bus.rx_valid = 1'b0;
                check_val({name, " rx_out_valid"}, 32'(bus.rx_out_valid), 32'd1);
                check_val({name, " rx_out_data"}, 32'(bus.rx_out_data), 32'(b));
                tick();
                check_val({name, " rx_out pulse"}, 32'(bus.rx_out_valid), 32'd0);
            end
        end
    endtask

`ifdef PS2_SW_CMD_PORT_EN
    task automatic sw_txn(input bit ack, input string name);
        bit seen;
        bit done;
        bit ok;
        seen = 1'b0; done = 1'b0; ok = 1'b0;
        got_q.delete();
        bus.sw_cmd       = 8'hF5;
        bus.sw_cmd_valid = 1'b1;
        tick();
        bus.sw_cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.send_command) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check_val({name, " sw send"}, 32'(seen), 32'd1);
        if (seen) dev_txn(1'b0, ack ? 0 : 2, 0, 1'b0);
        check_val({name, " sw byte"}, (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'hF5);
        for (int i = 0; i < 80; i++) begin
            if (bus.sw_done) begin
                done = 1'b1;
                ok   = bus.sw_ack_ok;
                break;
            end
            tick();
        end
        check_val({name, " sw_done"}, 32'(done), 32'd1);
        check_val({name, " sw_ack_ok"}, 32'(ok), 32'(ack));
    endtask
`endif

    initial begin
        bool_init: begin
            bus.start                         = 1'b0;
            bus.command_was_sent              = 1'b0;
            bus.error_communication_timed_out = 1'b0;
            bus.rx_data                       = 8'h00;
            bus.rx_valid                      = 1'b0;
            bus.sw_cmd                        = 8'h00;
            bus.sw_cmd_valid                  = 1'b0;
        end
        repeat (3) tick();
        check_val("reset send_command", 32'(bus.send_command), 32'd0);
        check_val("reset the_command", 32'(bus.the_command), 32'd0);
        check_val("reset busy", 32'(bus.busy), 32'd0);
        check_val("reset init_done", 32'(bus.init_done), 32'd0);
        check_val("reset init_error", 32'(bus.init_error), 32'd0);
        check_val("reset rx_out_valid", 32'(bus.rx_out_valid), 32'd0);
        check_val("reset sw_done", 32'(bus.sw_done), 32'd0);
        check_val("reset sw_cmd_ready", 32'(bus.sw_cmd_ready), 32'd0);
        reset = 1'b0;
        tick();

        plan_clear();
        run_scenario("basic");

`ifdef PS2_SW_CMD_PORT_EN
        check_val("sw_cmd_ready in DONE", 32'(bus.sw_cmd_ready), 32'd1);
        sw_txn(1'b1, "sw FA");
        sw_txn(1'b0, "sw FC");
`else
        check_val("sw_cmd_ready disabled", 32'(bus.sw_cmd_ready), 32'd0);
        bus.sw_cmd       = 8'hF5;
        bus.sw_cmd_valid = 1'b1;
        repeat (3) tick();
        bus.sw_cmd_valid = 1'b0;
        check_val("sw ignored busy", 32'(bus.busy), 32'd0);
        check_val("sw ignored send", 32'(bus.send_command), 32'd0);
`endif

        plan_clear();
        plan_reply[1] = 1;
        plan_reply[2] = 1;
        run_scenario("fe_retry");

        plan_clear();
        for (int k = 0; k < 32; k++) plan_reply[k] = 4;
        run_scenario("no_ack");

        plan_clear();
        plan_txto[0] = 1'b1;
        run_scenario("tx_timeout");

        for (int s = 0; s < 12; s++) begin
            plan_random();
            run_scenario($sformatf("rand%0d", s));
        end

        // Reset while a command is being transmitted.
        begin
            bit seen;
            seen = 1'b0;
            tick();
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (bus.send_command) begin
                    seen = 1'b1;
                    break;
                end
                tick();
            end
            check_val("rst_mid send seen", 32'(seen), 32'd1);
            reset = 1'b1;
            tick();
            check_val("rst_mid send_command", 32'(bus.send_command), 32'd0);
            check_val("rst_mid busy", 32'(bus.busy), 32'd0);
            check_val("rst_mid init_done", 32'(bus.init_done), 32'd0);
            reset = 1'b0;
            repeat (3) tick();
            check_val("rst_mid idle stays", 32'(bus.send_command), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
